// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings and NZCV flag / flag-write bit positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational 16-way condition decode against an NZCV flag vector.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = flags[FLAG_N];
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        v    = flags[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV register, condition gating of control strobes,
// and the registered hand-off to the next stage with stall/flush.
module cond_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       flush,
    input  logic       valid_in,
    input  logic [3:0] cond,
    input  logic [1:0] flag_w,
    input  logic [3:0] alu_flags,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    output logic       cond_ex,
    output logic [3:0] flags,
    output logic       valid_out,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write
);

    logic [3:0] flags_q, flags_d;
    logic       valid_q, valid_d;
    logic       pc_src_q, pc_src_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_write_q, mem_write_d;
    logic       pass;
    logic       take;

    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags_q),
        .pass  (pass)
    );

    assign cond_ex = valid_in & pass;
    assign take    = en & ~flush & cond_ex;

    always_comb begin
        flags_d     = flags_q;
        valid_d     = valid_q;
        pc_src_d    = pc_src_q;
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;

        // N/Z and C/V halves are written independently so logical ops keep carry/overflow.
        if (take && flag_w[FW_NZ]) begin
            flags_d[FLAG_N] = alu_flags[FLAG_N];
            flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (take && flag_w[FW_CV]) begin
            flags_d[FLAG_C] = alu_flags[FLAG_C];
            flags_d[FLAG_V] = alu_flags[FLAG_V];
        end

        if (flush) begin
            valid_d     = 1'b0;
            pc_src_d    = 1'b0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
        end else if (en) begin
            valid_d     = cond_ex;
            pc_src_d    = cond_ex & pcs;
            reg_write_d = cond_ex & reg_w;
            mem_write_d = cond_ex & mem_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= 4'b0000;
            valid_q     <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            valid_q     <= valid_d;
            pc_src_q    <= pc_src_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign flags     = flags_q;
    assign valid_out = valid_q;
    assign pc_src    = pc_src_q;
    assign reg_write = reg_write_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios, full cond x flags sweep,
// and random traffic against a behavioural model.
module tb_cond_unit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic       valid_in;
    logic [3:0] cond;
    logic [1:0] flag_w;
    logic [3:0] alu_flags;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       cond_ex;
    logic [3:0] flags;
    logic       valid_out;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [3:0] m_flags;
    logic       m_valid, m_pc, m_rw, m_mw;

    cond_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .valid_in  (valid_in),
        .cond      (cond),
        .flag_w    (flag_w),
        .alu_flags (alu_flags),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .cond_ex   (cond_ex),
        .flags     (flags),
        .valid_out (valid_out),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Even codes test a base predicate, odd codes its complement; 15 is thus "never".
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic [7:0] base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        base = {1'b1, (!z && (n == v)), (n == v), (cy && !z), v, n, cy, z};
        return c[0] ? !base[c[3:1]] : base[c[3:1]];
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".flags"}, {4'h0, flags}, {4'h0, m_flags});
        chk({tag, ".vout"},  {7'h0, valid_out}, {7'h0, m_valid});
        chk({tag, ".pcsrc"}, {7'h0, pc_src},    {7'h0, m_pc});
        chk({tag, ".regw"},  {7'h0, reg_write}, {7'h0, m_rw});
        chk({tag, ".memw"},  {7'h0, mem_write}, {7'h0, m_mw});
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        m_valid = 1'b0; m_pc = 1'b0; m_rw = 1'b0; m_mw = 1'b0;
    endtask

    // Drive one cycle of stimulus, check cond_ex combinationally, clock, check registers.
    task automatic step(input string tag, input logic e, input logic fl, input logic vi,
                        input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                        input logic p, input logic r, input logic m);
        logic ce;
        en = e; flush = fl; valid_in = vi; cond = c; flag_w = fw; alu_flags = af;
        pcs = p; reg_w = r; mem_w = m;
        #1;
        ce = vi && ref_cond(c, m_flags);
        chk({tag, ".cond_ex"}, {7'h0, cond_ex}, {7'h0, ce});
        @(posedge clk);
        if (fl) begin
            m_valid = 0; m_pc = 0; m_rw = 0; m_mw = 0;
        end else if (e) begin
            m_valid = ce; m_pc = ce && p; m_rw = ce && r; m_mw = ce && m;
            if (ce && fw[1]) m_flags[3:2] = af[3:2];
            if (ce && fw[0]) m_flags[1:0] = af[1:0];
        end
        #1;
        check_outs(tag);
    endtask

    initial begin
        logic [3:0] ref_fl;
        // asynchronous reset with random inputs, before any clock edge
        rst_n = 1'b0;
        en = 1'($urandom); flush = 1'($urandom); valid_in = 1'($urandom);
        cond = 4'($urandom); flag_w = 2'($urandom); alu_flags = 4'($urandom);
        pcs = 1'($urandom); reg_w = 1'($urandom); mem_w = 1'($urandom);
        model_reset();
        #2;
        check_outs("reset");
        @(posedge clk); #1;
        check_outs("reset_hold");
        rst_n = 1'b1;

        // ADDS (AL, writes all flags) then BEQ
        step("adds", 1, 0, 1, 4'd14, 2'b11, 4'b0110, 0, 1, 0);
        chk("adds.flags_abs", {4'h0, flags}, 8'h06);
        chk("adds.regw_abs",  {7'h0, reg_write}, 8'h01);
        step("beq", 1, 0, 1, 4'd0, 2'b00, 4'b0000, 1, 0, 0);
        chk("beq.pcsrc_abs", {7'h0, pc_src}, 8'h01);

        // half update: only N,Z written
        step("setall", 1, 0, 1, 4'd14, 2'b11, 4'b1111, 0, 0, 0);
        step("half",   1, 0, 1, 4'd14, 2'b10, 4'b0000, 0, 1, 0);
        chk("half.flags_abs", {4'h0, flags}, 8'h03);

        // failed condition with flags 0000
        step("clr",  1, 0, 1, 4'd14, 2'b11, 4'b0000, 0, 0, 0);
        step("fail", 1, 0, 1, 4'd0,  2'b11, 4'b1111, 1, 1, 1);
        chk("fail.vout_abs", {7'h0, valid_out}, 8'h00);

        // stall 3 cycles, then flush while stalled
        step("pre_stall", 1, 0, 1, 4'd14, 2'b00, 4'b0000, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 0, 1, 4'd14, 2'b11, 4'b1010, 0, 1, 1);
        chk("stall.regw_abs", {7'h0, reg_write}, 8'h01);
        step("flush_stall", 0, 1, 1, 4'd14, 2'b11, 4'b1010, 1, 1, 1);
        step("flush_en",    1, 1, 1, 4'd14, 2'b11, 4'b0101, 1, 1, 1);

        // sweep all cond codes against all flag values
        for (int f = 0; f < 16; f++) begin
            step("sweep_set", 1, 0, 1, 4'd14, 2'b11, 4'(f), 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                valid_in = 1'b1; cond = 4'(c); en = 1'b0; flush = 1'b0;
                #1;
                chk("sweep", {7'h0, cond_ex}, {7'h0, ref_cond(4'(c), 4'(f))});
            end
        end
        // explicit signed-compare corners: N=1,V=0 -> LT true, GE false
        step("corner_set", 1, 0, 1, 4'd14, 2'b11, 4'b1000, 0, 0, 0);
        valid_in = 1'b1; cond = 4'd11; #1;
        chk("corner.lt", {7'h0, cond_ex}, 8'h01);
        cond = 4'd10; #1;
        chk("corner.ge", {7'h0, cond_ex}, 8'h00);
        cond = 4'd13; #1;
        chk("corner.le", {7'h0, cond_ex}, 8'h01);
        cond = 4'd15; #1;
        chk("corner.nv", {7'h0, cond_ex}, 8'h00);
        valid_in = 1'b0; cond = 4'd14; #1;
        chk("novalid", {7'h0, cond_ex}, 8'h00);

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 5) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));

        // reset asserted mid-stall wins immediately
        step("pre_rst", 1, 0, 1, 4'd14, 2'b11, 4'b1101, 1, 1, 1);
        en = 1'b0; flush = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        ref_fl = 4'b1001;
        step("post_rst", 1, 0, 1, 4'd14, 2'b11, ref_fl, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
